full_subtractor: RTL

Pipelined W-bit subtractor computing D = a − b − bi with a borrow-out, one byte slice per pipeline stage. It is the counterpart of the team's byte-sliced carry-chain adder and is used on the same datapaths for difference/compare operations. Unlike the adder, operands are skewed and results deskewed internally, so each result word is coherent. The block has a valid/ready handshake with full-pipeline backpressure.

---
 rtl/full_subtractor_if.sv | 30 +++
 rtl/full_subtractor.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/full_subtractor_if.sv
// Operand/result handshake bundle for full_subtractor.
// Both sides use valid/ready: a word moves on a clock edge where valid && ready
// are both high. A producer holds valid and data steady until that edge.
// in_ready may depend combinationally on out_ready, so a consumer must not make
// out_ready depend on in_valid.
interface full_subtractor_if #(
  parameter int W = 64
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bi;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] D;
  logic         Bo;

  // Environment side: offers operands and accepts results.
  modport master (
    output in_valid, a, b, bi, out_ready,
    input  in_ready, out_valid, D, Bo
  );

  // Subtractor side.
  modport slave (
    input  in_valid, a, b, bi, out_ready,
    output in_ready, out_valid, D, Bo
  );
endinterface

// File: rtl/full_subtractor.sv
// Byte-sliced pipelined subtractor: D = a - b - bi (mod 2^W), Bo = borrow-out.
// One byte is resolved per stage, so a W-bit word takes N = W/8 stages.
// Operands are skewed on the way in (each stage carries the bytes it has not
// yet consumed) and the result is deskewed on the way out (each stage carries
// the bytes already produced), so every presented word is coherent.
// The whole pipeline advances together; a stall at the output freezes every
// stage, and in_ready mirrors that advance.
// W must be a multiple of 8 and at least 8.
// Optional feature: define FULL_SUB_SAT_EN to clamp D to 0 when the final
// borrow is set (unsigned saturation). Bo still reports the underflow.
module full_subtractor #(
  parameter int W = 64
) (
  input  logic                 clk,
  input  logic                 resetn,
  full_subtractor_if.slave     bus
);

  localparam int N = W / 8;

  logic adv;

  genvar k;
  generate
    for (k = 0; k < N; k++) begin : g_stage
      // Result bytes 0..k live in this stage.
      localparam int RW = 8 * (k + 1);

      logic          vld;
      logic [RW-1:0] res;
      logic          brw;

      logic          vld_n;
      logic [7:0]    x_byte;
      logic [7:0]    y_byte;
      logic          b_in;
      logic [8:0]    diff;
      logic [RW-1:0] res_n;

      if (k == 0) begin : g_src
        // First stage takes byte 0 and the borrow-in straight from the inputs.
        always_comb begin
          vld_n  = bus.in_valid;
          x_byte = bus.a[7:0];
          y_byte = bus.b[7:0];
          b_in   = bus.bi;
        end
      end else begin : g_src
        // Later stages take the lowest carried operand byte and the registered
        // borrow of the previous stage.
        always_comb begin
          vld_n  = g_stage[k-1].vld;
          x_byte = g_stage[k-1].g_carry.opa[7:0];
          y_byte = g_stage[k-1].g_carry.opb[7:0];
          b_in   = g_stage[k-1].brw;
        end
      end

      // 9-bit byte subtract: low 8 bits are the result byte, bit 8 is borrow-out.
      always_comb begin
        diff = {1'b0, x_byte} - {1'b0, y_byte} - {8'd0, b_in};
      end

      if (k == 0) begin : g_res
        // Byte 0 starts the result word.
        always_comb begin
          res_n = diff[7:0];
`ifdef FULL_SUB_SAT_EN
          if ((k == N - 1) && diff[8]) begin
            res_n = '0;
          end
`endif
        end
      end else begin : g_res
        // Append this byte above the bytes already resolved upstream.
        always_comb begin
          res_n = {diff[7:0], g_stage[k-1].res};
`ifdef FULL_SUB_SAT_EN
          if ((k == N - 1) && diff[8]) begin
            res_n = '0;
          end
`endif
        end
      end

      // Stage register: cleared by reset, loaded only on a global advance.
      always_ff @(posedge clk) begin
        if (!resetn) begin
          vld <= 1'b0;
          res <= '0;
          brw <= 1'b0;
        end else if (adv) begin
          vld <= vld_n;
          res <= res_n;
          brw <= diff[8];
        end
      end

      if (k < N - 1) begin : g_carry
        // Operand bytes k+1..N-1 still waiting for their stage.
        localparam int OW = W - RW;

        logic [OW-1:0] opa;
        logic [OW-1:0] opb;
        logic [OW-1:0] opa_n;
        logic [OW-1:0] opb_n;

        if (k == 0) begin : g_ld
          // Stage 0 keeps everything above byte 0.
          always_comb begin
            opa_n = bus.a[W-1:8];
            opb_n = bus.b[W-1:8];
          end
        end else begin : g_ld
          // Drop the byte consumed by this stage, pass the rest along.
          always_comb begin
            opa_n = g_stage[k-1].g_carry.opa[OW+7:8];
            opb_n = g_stage[k-1].g_carry.opb[OW+7:8];
          end
        end

        // Operand carry register, same advance/reset rules as the result.
        always_ff @(posedge clk) begin
          if (!resetn) begin
            opa <= '0;
            opb <= '0;
          end else if (adv) begin
            opa <= opa_n;
            opb <= opb_n;
          end
        end
      end
    end
  endgenerate

  // The pipeline moves when the last stage is empty or being drained.
  always_comb begin
    adv = !g_stage[N-1].vld || bus.out_ready;
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = g_stage[N-1].vld;
  assign bus.D         = g_stage[N-1].res;
  assign bus.Bo        = g_stage[N-1].brw;

endmodule
